// File: rtl/cp_alloc_ctrl.sv
// ----------------------------------------------------------------------------
// cp_alloc_ctrl
//
// Checkpoint-array allocation controller. Hands out checkpoint slots in
// program order to dispatching branches, writes the checkpoint table through
// o_check/o_check_idx, retires slots in order once their branch resolves
// correctly, and on a mispredict frees the mispredicted slot plus every
// younger slot, then spends one cycle in RECOVER driving o_rat_restore so the
// RAT reloads the table entry selected by o_recover_idx.
//
// Ports
//   clock, reset            clock; synchronous active-high reset
//   i_alloc_req             dispatch wants a checkpoint this cycle
//   o_alloc_gnt / o_check   slot granted; checkpoint table write strobe
//   o_check_idx             slot being written (current tail)
//   i_resolve_valid/_idx    a branch resolved, and its slot
//   i_resolve_mispredict    that branch was mispredicted
//   i_flush_all             discard every checkpoint
//   o_recover_idx           checkpoint table read index
//   o_rat_restore           RAT loads the checkpoint this cycle
//   o_recovering            FSM is in RECOVER; dispatch held
//   o_cp_count, o_cp_full   live slot count and full flag
// ----------------------------------------------------------------------------
module cp_alloc_ctrl #(
    parameter int CP_SIZE = 4,
    parameter int IDX_W   = $clog2(CP_SIZE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_alloc_req,
    output logic             o_alloc_gnt,
    output logic             o_check,
    output logic [IDX_W-1:0] o_check_idx,
    input  logic             i_resolve_valid,
    input  logic [IDX_W-1:0] i_resolve_idx,
    input  logic             i_resolve_mispredict,
    input  logic             i_flush_all,
    output logic [IDX_W-1:0] o_recover_idx,
    output logic             o_rat_restore,
    output logic             o_recovering,
    output logic [IDX_W:0]   o_cp_count,
    output logic             o_cp_full
);

    localparam int CNT_W = IDX_W + 1;

    typedef enum logic {
        S_IDLE,
        S_RECOVER
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_head;
    logic [IDX_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [CP_SIZE-1:0] r_valid;
    logic [CP_SIZE-1:0] r_resolved;
    logic [IDX_W-1:0]   r_rec_idx;

    logic               w_full;
    logic               w_mispredict;
    logic               w_correct;
    logic               w_retire;
    logic               w_grant;
    logic [IDX_W-1:0]   w_mp_offset;
    logic [CP_SIZE-1:0] w_younger;

    assign w_full       = (r_count == CNT_W'(CP_SIZE));
    assign w_mispredict = i_resolve_valid & i_resolve_mispredict & r_valid[i_resolve_idx];
    assign w_correct    = i_resolve_valid & ~i_resolve_mispredict & r_valid[i_resolve_idx];
    assign w_retire     = r_valid[r_head] & r_resolved[r_head];
    // Any mispredict indication blocks the grant, even one that turns out to
    // target an invalid slot; keeps the grant path independent of valid[].
    assign w_grant      = i_alloc_req & ~w_full & (r_state == S_IDLE) & ~i_flush_all
                        & ~(i_resolve_valid & i_resolve_mispredict);

    // Age of the mispredicted slot relative to head; also the surviving count.
    assign w_mp_offset  = i_resolve_idx - r_head;

    // A slot is squashed when it is at least as young as the mispredicted one.
    // Measuring age from head (not tail) handles the full case, where
    // head == tail and a tail-based range would be empty.
    always_comb begin
        w_younger = '0;
        for (int i = 0; i < CP_SIZE; i++) begin
            logic [IDX_W-1:0] v_age;
            v_age        = IDX_W'(i) - r_head;
            w_younger[i] = (v_age >= w_mp_offset);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_valid    <= '0;
            r_resolved <= '0;
            r_rec_idx  <= '0;
        end else if (i_flush_all) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_valid    <= '0;
            r_resolved <= '0;
        end else if (w_mispredict) begin
            // Also taken from RECOVER: an older branch re-targets the restore.
            r_valid    <= r_valid & ~w_younger;
            r_resolved <= r_resolved & ~w_younger;
            r_tail     <= i_resolve_idx;
            r_count    <= {1'b0, w_mp_offset};
            r_rec_idx  <= i_resolve_idx;
            r_state    <= S_RECOVER;
        end else begin
            if (w_correct) begin
                r_resolved[i_resolve_idx] <= 1'b1;
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            // Grant never targets head while head is live (blocked when full),
            // so it cannot collide with the retire or resolve writes above.
            if (w_grant) begin
                r_valid[r_tail]    <= 1'b1;
                r_resolved[r_tail] <= 1'b0;
                r_tail             <= r_tail + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_grant) - CNT_W'(w_retire);
            r_state <= S_IDLE;
        end
    end

    assign o_alloc_gnt   = w_grant;
    assign o_check       = w_grant;
    assign o_check_idx   = r_tail;
    assign o_recover_idx = r_rec_idx;
    assign o_rat_restore = (r_state == S_RECOVER);
    assign o_recovering  = (r_state == S_RECOVER);
    assign o_cp_count    = r_count;
    assign o_cp_full     = w_full;

endmodule

// File: tb/tb_cp_alloc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cp_alloc_ctrl
//
// Self-checking bench for cp_alloc_ctrl (CP_SIZE = 4). Inputs change on the
// falling edge, outputs are sampled 1 time unit later. Expected grant/index
// pairs go into a scoreboard queue as each request is driven and are popped
// when the combinational grant is sampled.
// ----------------------------------------------------------------------------
module tb_cp_alloc_ctrl;

    logic       clock;
    logic       reset;
    logic       alloc_req;
    logic       alloc_gnt;
    logic       check;
    logic [1:0] check_idx;
    logic       resolve_valid;
    logic [1:0] resolve_idx;
    logic       resolve_mispredict;
    logic       flush_all;
    logic [1:0] recover_idx;
    logic       rat_restore;
    logic       recovering;
    logic [2:0] cp_count;
    logic       cp_full;

    typedef struct packed {
        logic       gnt;
        logic [1:0] idx;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_err    = 0;

    cp_alloc_ctrl #(.CP_SIZE(4)) dut (
        .clock                (clock),
        .reset                (reset),
        .i_alloc_req          (alloc_req),
        .o_alloc_gnt          (alloc_gnt),
        .o_check              (check),
        .o_check_idx          (check_idx),
        .i_resolve_valid      (resolve_valid),
        .i_resolve_idx        (resolve_idx),
        .i_resolve_mispredict (resolve_mispredict),
        .i_flush_all          (flush_all),
        .o_recover_idx        (recover_idx),
        .o_rat_restore        (rat_restore),
        .o_recovering         (recovering),
        .o_cp_count           (cp_count),
        .o_cp_full            (cp_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic drive(input logic req, input logic rv, input logic [1:0] ridx,
                         input logic rmis, input logic fl);
        alloc_req          = req;
        resolve_valid      = rv;
        resolve_idx        = ridx;
        resolve_mispredict = rmis;
        flush_all          = fl;
    endtask

    // Grants idx first..first+n-1 on consecutive cycles from an unstalled state.
    task automatic test_grant_run(input int first, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0, 0, 0);
            e.gnt = 1'b1; e.idx = 2'(first + i); sb_q.push_back(e);
            #1;
            e = sb_q.pop_front();
            n_checks++; if (alloc_gnt !== e.gnt) begin n_err++; $display("FAIL %s_gnt%0d got=%0b want=%0b", nm, i, alloc_gnt, e.gnt); end
            n_checks++; if (check_idx !== e.idx) begin n_err++; $display("FAIL %s_idx%0d got=%0d want=%0d", nm, i, check_idx, e.idx); end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        #1;
        n_checks++; if (alloc_gnt !== 1'b0)   begin n_err++; $display("FAIL reset_gnt got=%0b want=0", alloc_gnt); end
        n_checks++; if (check !== 1'b0)       begin n_err++; $display("FAIL reset_check got=%0b want=0", check); end
        n_checks++; if (check_idx !== 2'd0)   begin n_err++; $display("FAIL reset_check_idx got=%0d want=0", check_idx); end
        n_checks++; if (recover_idx !== 2'd0) begin n_err++; $display("FAIL reset_recover_idx got=%0d want=0", recover_idx); end
        n_checks++; if (rat_restore !== 1'b0) begin n_err++; $display("FAIL reset_rat_restore got=%0b want=0", rat_restore); end
        n_checks++; if (recovering !== 1'b0)  begin n_err++; $display("FAIL reset_recovering got=%0b want=0", recovering); end
        n_checks++; if (cp_count !== 3'd0)    begin n_err++; $display("FAIL reset_count got=%0d want=0", cp_count); end
        n_checks++; if (cp_full !== 1'b0)     begin n_err++; $display("FAIL reset_full got=%0b want=0", cp_full); end
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0);
            e.gnt = (i < 4); e.idx = 2'(i); sb_q.push_back(e);
            #1;
            e = sb_q.pop_front();
            n_checks++; if (alloc_gnt !== e.gnt) begin n_err++; $display("FAIL fill_gnt%0d got=%0b want=%0b", i, alloc_gnt, e.gnt); end
            n_checks++; if (check !== e.gnt)     begin n_err++; $display("FAIL fill_check%0d got=%0b want=%0b", i, check, e.gnt); end
            n_checks++; if (check_idx !== e.idx) begin n_err++; $display("FAIL fill_idx%0d got=%0d want=%0d", i, check_idx, e.idx); end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (cp_count !== 3'd4) begin n_err++; $display("FAIL fill_count got=%0d want=4", cp_count); end
        n_checks++; if (cp_full !== 1'b1)  begin n_err++; $display("FAIL fill_full got=%0b want=1", cp_full); end
        tick();
    endtask

    // Full; resolving head frees a slot two edges later, then grant wraps to 0.
    task automatic test_wrap();
        for (int c = 0; c < 3; c++) begin
            drive(1, (c == 0), 0, 0, 0);
            e.gnt = (c == 2); e.idx = 2'd0; sb_q.push_back(e);
            #1;
            e = sb_q.pop_front();
            if (c == 2) begin
                n_checks++; if (cp_count !== 3'd3) begin n_err++; $display("FAIL wrap_count got=%0d want=3", cp_count); end
                n_checks++; if (cp_full !== 1'b0)  begin n_err++; $display("FAIL wrap_full got=%0b want=0", cp_full); end
            end
            n_checks++; if (alloc_gnt !== e.gnt) begin n_err++; $display("FAIL wrap_gnt%0d got=%0b want=%0b", c, alloc_gnt, e.gnt); end
            n_checks++; if (check_idx !== e.idx) begin n_err++; $display("FAIL wrap_idx%0d got=%0d want=%0d", c, check_idx, e.idx); end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (cp_count !== 3'd4) begin n_err++; $display("FAIL wrap_refill got=%0d want=4", cp_count); end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 0, 0, 0, 1);
        e.gnt = 1'b0; e.idx = 2'd1; sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        n_checks++; if (alloc_gnt !== e.gnt) begin n_err++; $display("FAIL flush_gnt got=%0b want=%0b", alloc_gnt, e.gnt); end
        n_checks++; if (check_idx !== e.idx) begin n_err++; $display("FAIL flush_pre_idx got=%0d want=%0d", check_idx, e.idx); end
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (cp_count !== 3'd0)  begin n_err++; $display("FAIL flush_count got=%0d want=0", cp_count); end
        n_checks++; if (check_idx !== 2'd0) begin n_err++; $display("FAIL flush_idx got=%0d want=0", check_idx); end
        tick();
    endtask

    task automatic test_ooo_retire();
        int exp_cnt[5] = '{4, 3, 2, 1, 1};
        int order[3]   = '{2, 1, 0};
        test_grant_run(0, 4, "ooo_fill");
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 2'(order[k]), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (cp_count !== 3'(exp_cnt[c])) begin n_err++; $display("FAIL ooo_count%0d got=%0d want=%0d", c, cp_count, exp_cnt[c]); end
            tick();
        end
        // head is now 3, tail 0: three more grants fill it.
        test_grant_run(0, 3, "ooo_regrant");
        #1;
        n_checks++; if (cp_full !== 1'b1) begin n_err++; $display("FAIL ooo_full got=%0b want=1", cp_full); end
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_mispredict();
        test_grant_run(0, 4, "mp_fill");
        for (int c = 0; c < 3; c++) begin
            drive(1, (c == 0), 2'd1, (c == 0), 0);
            e.gnt = (c == 2); e.idx = (c == 0) ? 2'd0 : 2'd1; sb_q.push_back(e);
            #1;
            e = sb_q.pop_front();
            n_checks++; if (alloc_gnt !== e.gnt) begin n_err++; $display("FAIL mp_gnt%0d got=%0b want=%0b", c, alloc_gnt, e.gnt); end
            n_checks++; if (check_idx !== e.idx) begin n_err++; $display("FAIL mp_idx%0d got=%0d want=%0d", c, check_idx, e.idx); end
            n_checks++; if (rat_restore !== (c == 1)) begin n_err++; $display("FAIL mp_restore%0d got=%0b want=%0b", c, rat_restore, (c == 1)); end
            if (c == 1) begin
                n_checks++; if (recovering !== 1'b1)  begin n_err++; $display("FAIL mp_recovering got=%0b want=1", recovering); end
                n_checks++; if (recover_idx !== 2'd1) begin n_err++; $display("FAIL mp_recover_idx got=%0d want=1", recover_idx); end
                n_checks++; if (cp_count !== 3'd1)    begin n_err++; $display("FAIL mp_count got=%0d want=1", cp_count); end
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (cp_count !== 3'd2) begin n_err++; $display("FAIL mp_after_count got=%0d want=2", cp_count); end
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_mispredict_edges();
        test_grant_run(0, 1, "mpe_fill");
        // Mispredict on an invalid slot: still blocks the grant, otherwise ignored.
        drive(1, 1, 2'd2, 1, 0);
        e.gnt = 1'b0; e.idx = 2'd1; sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        n_checks++; if (alloc_gnt !== e.gnt) begin n_err++; $display("FAIL mpe_inv_gnt got=%0b want=%0b", alloc_gnt, e.gnt); end
        n_checks++; if (check_idx !== e.idx) begin n_err++; $display("FAIL mpe_inv_idx got=%0d want=%0d", check_idx, e.idx); end
        tick();
        drive(0, 1, 2'd0, 1, 0);
        #1;
        n_checks++; if (rat_restore !== 1'b0) begin n_err++; $display("FAIL mpe_inv_restore got=%0b want=0", rat_restore); end
        n_checks++; if (cp_count !== 3'd1)    begin n_err++; $display("FAIL mpe_inv_count got=%0d want=1", cp_count); end
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (rat_restore !== 1'b1) begin n_err++; $display("FAIL mpe_head_restore got=%0b want=1", rat_restore); end
        n_checks++; if (cp_count !== 3'd0)    begin n_err++; $display("FAIL mpe_head_count got=%0d want=0", cp_count); end
        n_checks++; if (recover_idx !== 2'd0) begin n_err++; $display("FAIL mpe_head_recover_idx got=%0d want=0", recover_idx); end
        n_checks++; if (check_idx !== 2'd0)   begin n_err++; $display("FAIL mpe_head_tail got=%0d want=0", check_idx); end
        tick();
        #1;
        n_checks++; if (rat_restore !== 1'b0) begin n_err++; $display("FAIL mpe_one_cycle got=%0b want=0", rat_restore); end
        tick();
    endtask

    task automatic test_recover_exit();
        // flush_all during RECOVER
        test_grant_run(0, 2, "rx_fill_a");
        drive(0, 1, 2'd1, 1, 0);
        tick();
        drive(1, 0, 0, 0, 1);
        e.gnt = 1'b0; e.idx = 2'd1; sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        n_checks++; if (alloc_gnt !== e.gnt)  begin n_err++; $display("FAIL rx_flush_gnt got=%0b want=%0b", alloc_gnt, e.gnt); end
        n_checks++; if (check_idx !== e.idx)  begin n_err++; $display("FAIL rx_flush_idx got=%0d want=%0d", check_idx, e.idx); end
        n_checks++; if (rat_restore !== 1'b1) begin n_err++; $display("FAIL rx_flush_in_recover got=%0b want=1", rat_restore); end
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (rat_restore !== 1'b0) begin n_err++; $display("FAIL rx_flush_restore got=%0b want=0", rat_restore); end
        n_checks++; if (recovering !== 1'b0)  begin n_err++; $display("FAIL rx_flush_recovering got=%0b want=0", recovering); end
        n_checks++; if (cp_count !== 3'd0)    begin n_err++; $display("FAIL rx_flush_count got=%0d want=0", cp_count); end
        n_checks++; if (check_idx !== 2'd0)   begin n_err++; $display("FAIL rx_flush_tail got=%0d want=0", check_idx); end
        tick();
        // reset during RECOVER
        test_grant_run(0, 2, "rx_fill_b");
        drive(0, 1, 2'd1, 1, 0);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (rat_restore !== 1'b1) begin n_err++; $display("FAIL rx_rst_in_recover got=%0b want=1", rat_restore); end
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (rat_restore !== 1'b0) begin n_err++; $display("FAIL rx_rst_restore got=%0b want=0", rat_restore); end
        n_checks++; if (cp_count !== 3'd0)    begin n_err++; $display("FAIL rx_rst_count got=%0d want=0", cp_count); end
        n_checks++; if (recover_idx !== 2'd0) begin n_err++; $display("FAIL rx_rst_recover_idx got=%0d want=0", recover_idx); end
        n_checks++; if (check_idx !== 2'd0)   begin n_err++; $display("FAIL rx_rst_tail got=%0d want=0", check_idx); end
        tick();
    endtask

    // Grant + resolve + retire in one cycle, then a nested (older) mispredict.
    task automatic test_back_to_back();
        test_grant_run(0, 1, "b2b_fill");
        for (int c = 0; c < 2; c++) begin
            drive(1, (c == 0), 2'd0, 0, 0);
            e.gnt = 1'b1; e.idx = 2'(c + 1); sb_q.push_back(e);
            #1;
            e = sb_q.pop_front();
            n_checks++; if (alloc_gnt !== e.gnt) begin n_err++; $display("FAIL b2b_gnt%0d got=%0b want=%0b", c, alloc_gnt, e.gnt); end
            n_checks++; if (check_idx !== e.idx) begin n_err++; $display("FAIL b2b_idx%0d got=%0d want=%0d", c, check_idx, e.idx); end
            tick();
        end
        drive(0, 1, 2'd2, 1, 0);
        #1;
        n_checks++; if (cp_count !== 3'd2) begin n_err++; $display("FAIL b2b_net_count got=%0d want=2", cp_count); end
        tick();
        drive(0, 1, 2'd1, 1, 0);
        #1;
        n_checks++; if (rat_restore !== 1'b1) begin n_err++; $display("FAIL b2b_rec1_restore got=%0b want=1", rat_restore); end
        n_checks++; if (recover_idx !== 2'd2) begin n_err++; $display("FAIL b2b_rec1_idx got=%0d want=2", recover_idx); end
        n_checks++; if (cp_count !== 3'd1)    begin n_err++; $display("FAIL b2b_rec1_count got=%0d want=1", cp_count); end
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (rat_restore !== 1'b1) begin n_err++; $display("FAIL b2b_rec2_restore got=%0b want=1", rat_restore); end
        n_checks++; if (recover_idx !== 2'd1) begin n_err++; $display("FAIL b2b_rec2_idx got=%0d want=1", recover_idx); end
        n_checks++; if (cp_count !== 3'd0)    begin n_err++; $display("FAIL b2b_rec2_count got=%0d want=0", cp_count); end
        n_checks++; if (check_idx !== 2'd1)   begin n_err++; $display("FAIL b2b_rec2_tail got=%0d want=1", check_idx); end
        tick();
        #1;
        n_checks++; if (rat_restore !== 1'b0) begin n_err++; $display("FAIL b2b_exit_restore got=%0b want=0", rat_restore); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(negedge clock);
        test_reset();
        test_fill();
        test_wrap();
        test_flush();
        test_ooo_retire();
        test_mispredict();
        test_mispredict_edges();
        test_recover_exit();
        test_back_to_back();
        n_checks++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
